mem_access_controller: RTL
==========================

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, number of ACCESS cycles without MOC before abort (used only with MEM_TIMEOUT_EN).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 CLR  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch request; held high until if_done.
REQ-005 if_addr  in  32  fetch byte address; fetch is always a word access.
REQ-006 da_req  in  1  data-access request; held high until da_done.
REQ-007 da_rw  in  1  1 = read, 0 = write.
REQ-008 da_type  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 da_addr / da_wdata  in  32 / 32  data address and write data.
REQ-010 MOC  in  1  memory-operation-complete from RAM.
REQ-011 MOV  out  1  memory-operation-valid to RAM.
REQ-012 RW, typeData, mem_addr, mem_wdata  out  1, 2, 32, 32  registered RAM command fields, stable while MOV = 1.
REQ-013 rdata  out  32  read data captured on MOC.
REQ-014 if_done, da_done  out  1  one-cycle completion pulses.
REQ-015 err  out  1  one-cycle error pulse, coincident with the matching done pulse.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, RELEASE.
REQ-018 In IDLE with any request pending, the block arbitrates, registers the command, and enters ACCESS on the next edge; MOV = 1 from the first ACCESS cycle.
REQ-019 Arbitration is round-robin: a lone request wins; on simultaneous requests the requester not granted last wins.
REQ-020 A data access with da_type 11, or misaligned (halfword addr[0] = 1, word addr[1:0] != 0), is not issued: MOV stays 0, and da_done and err pulse one cycle later; the FSM remains in IDLE.
REQ-021 In ACCESS, MOC sampled 1 ends the access: on a read, rdata is loaded; the matching done pulses the next cycle; MOV drops to 0; the FSM enters RELEASE.
REQ-022 In RELEASE, MOV = 0; the FSM returns to IDLE on the first cycle MOC = 0. Minimum request-to-done latency is 2 cycles.
REQ-023 A request deasserted mid-access is ignored; the access completes and done still pulses.
REQ-024 rdata holds its value until the next completed read; a write does not alter it.

Reset
REQ-025 CLR = 1 forces IDLE immediately.
REQ-026 CLR = 1 forces MOV, RW, done, err and busy to 0, typeData to 10, and mem_addr, mem_wdata and rdata to 0.
REQ-027 Reset sets last-grant to data, so fetch wins the first simultaneous arbitration; an in-flight access is abandoned without a done pulse.

Configuration
REQ-028 With MEM_TIMEOUT_EN defined, a counter tracks ACCESS cycles; after TIMEOUT_CYCLES cycles without MOC, the FSM drops MOV, pulses done and err, and enters RELEASE.
REQ-029 Without MEM_TIMEOUT_EN, no counter exists and ACCESS waits indefinitely for MOC.

Structure
REQ-030 Package mem_ctrl_pkg holds the state enum, the type codes TYPE_BYTE, TYPE_HALF and TYPE_WORD, and the RW_READ/RW_WRITE constants.
REQ-031 Sub-module mem_rr_arbiter (two requesters, last-grant flop, one-hot grant) is instantiated once.

Verification
REQ-032 Lone if_req, if_addr = 0x10, MOC asserted 3 cycles after MOV -> MOV high 3 cycles, RW = 1, typeData = 10, if_done pulse, rdata = RAM word.
REQ-033 if_req and da_req raised together after reset -> fetch served first, then data; then both again -> order alternates.
REQ-034 da_rw = 0, da_type = 01, da_addr = 0x21 -> MOV never asserts; da_done and err pulse together.
REQ-035 da_rw = 0, da_type = 00, da_addr = 0x05, da_wdata = 0xAB -> RAM byte 5 = 0xAB; rdata unchanged.
REQ-036 MEM_TIMEOUT_EN on, TIMEOUT_CYCLES = 16, MOC held 0 -> MOV drops after 16 cycles with err and done pulsing; MEM_TIMEOUT_EN off -> busy stays high.
REQ-037 CLR asserted mid-ACCESS -> MOV is 0 without waiting for a clock edge; no done pulse; after release the next request is served normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the memory access controller:
//            FSM state encoding, RAM access type codes, read/write codes and
//            the data-access legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;
  localparam logic [1:0] TYPE_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A data access is refused when its type is reserved or the address is
  // not naturally aligned for the access width.
  function automatic logic da_illegal(input logic [1:0] da_type,
                                      input logic [1:0] addr_lsb);
    logic bad;
    case (da_type)
      TYPE_BYTE: bad = 1'b0;
      TYPE_HALF: bad = addr_lsb[0];
      TYPE_WORD: bad = (addr_lsb != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Purpose  : Two-requester round-robin arbiter with a last-grant flop.
//            A lone request wins; on simultaneous requests the requester not
//            granted last wins. Reset makes "data" the last grant so fetch
//            wins the first tie.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            req_if, req_da  - fetch / data requests
//            accept          - the current grant is taken this cycle
//            grant[1:0]      - one-hot grant, bit0 = fetch, bit1 = data
// Revision : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_if,
  input  logic       req_da,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_da_q, last_da_d;

  always_comb begin
    grant = 2'b00;
    if (req_if && req_da) begin
      grant = last_da_q ? 2'b01 : 2'b10;
    end else if (req_if) begin
      grant = 2'b01;
    end else if (req_da) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    last_da_d = last_da_q;
    if (accept && (grant != 2'b00)) begin
      last_da_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_da_q <= 1'b1;
    end else begin
      last_da_q <= last_da_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_controller
// Purpose  : Arbitrates instruction-fetch and data-access requests onto a
//            single RAM handshake (MOV/MOC) through an IDLE/ACCESS/RELEASE FSM.
//            Optional build macro MEM_TIMEOUT_EN adds an ACCESS-cycle watchdog
//            that aborts after TIMEOUT_CYCLES cycles without MOC.
// Ports    : CLK, CLR                 - clock, asynchronous active-high reset
//            if_req, if_addr          - fetch request (always a word read)
//            da_req, da_rw, da_type,
//            da_addr, da_wdata        - data request and its command fields
//            MOC, mem_rdata           - RAM completion and read data
//            MOV, RW, typeData,
//            mem_addr, mem_wdata      - registered RAM command
//            rdata                    - last completed read data
//            if_done, da_done, err    - one-cycle completion / error pulses
//            busy                     - FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        da_req,
  input  logic        da_rw,
  input  logic [1:0]  da_type,
  input  logic [31:0] da_addr,
  input  logic [31:0] da_wdata,
  input  logic        MOC,
  input  logic [31:0] mem_rdata,
  output logic        MOV,
  output logic        RW,
  output logic [1:0]  typeData,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        if_done,
  output logic        da_done,
  output logic        err,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        mov_q, mov_d;
  logic        rw_q, rw_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        if_done_q, if_done_d;
  logic        da_done_q, da_done_d;
  logic        err_q, err_d;
  logic        owner_da_q, owner_da_d;

  logic [1:0]  grant;
  logic        accept;
  logic        tmo_hit;

  // While a done pulse is visible the requester has not yet had a chance to
  // drop its request, so arbitration waits one cycle to avoid a re-issue.
  assign accept = (state_q == S_IDLE) && (if_req || da_req) &&
                  !(if_done_q || da_done_q);

  mem_rr_arbiter u_arb (
    .clk    (CLK),
    .rst    (CLR),
    .req_if (if_req),
    .req_da (da_req),
    .accept (accept),
    .grant  (grant)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == S_ACCESS) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Fires in the last allowed ACCESS cycle so MOV is high exactly
  // TIMEOUT_CYCLES cycles.
  assign tmo_hit = (state_q == S_ACCESS) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mov_d      = mov_q;
    rw_d       = rw_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    owner_da_d = owner_da_q;
    if_done_d  = 1'b0;
    da_done_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (grant[0]) begin
            state_d    = S_ACCESS;
            mov_d      = 1'b1;
            rw_d       = RW_READ;
            type_d     = TYPE_WORD;
            addr_d     = if_addr;
            owner_da_d = 1'b0;
          end else if (grant[1]) begin
            if (da_illegal(da_type, da_addr[1:0])) begin
              da_done_d = 1'b1;
              err_d     = 1'b1;
            end else begin
              state_d    = S_ACCESS;
              mov_d      = 1'b1;
              rw_d       = da_rw;
              type_d     = da_type;
              addr_d     = da_addr;
              wdata_d    = da_wdata;
              owner_da_d = 1'b1;
            end
          end
        end
      end

      S_ACCESS: begin
        if (MOC || tmo_hit) begin
          state_d = S_RELEASE;
          mov_d   = 1'b0;
          if (owner_da_q) begin
            da_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
          if (MOC) begin
            if (rw_q == RW_READ) begin
              rdata_d = mem_rdata;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RELEASE: begin
        if (!MOC) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        mov_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= S_IDLE;
      mov_q      <= 1'b0;
      rw_q       <= 1'b0;
      type_q     <= TYPE_WORD;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      owner_da_q <= 1'b0;
      if_done_q  <= 1'b0;
      da_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mov_q      <= mov_d;
      rw_q       <= rw_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      owner_da_q <= owner_da_d;
      if_done_q  <= if_done_d;
      da_done_q  <= da_done_d;
      err_q      <= err_d;
    end
  end

  assign MOV       = mov_q;
  assign RW        = rw_q;
  assign typeData  = type_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign if_done   = if_done_q;
  assign da_done   = da_done_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
